// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if
// Purpose: register-access bus between a CPU-side master and the interrupt
//          controller. Every cycle with cs & as is one access. The slave
//          answers with a one-cycle rdy strobe in the following cycle.
// Signals:
//   cs      - slave select (master -> slave)
//   as      - address strobe (master -> slave)
//   rw      - 1 = read, 0 = write (master -> slave)
//   addr    - word register index (master -> slave)
//   wr_data - write data (master -> slave)
//   rd_data - read data, non-zero only while rdy (slave -> master)
//   rdy     - access-complete strobe (slave -> master)
interface irq_ctrl_if;
    logic        cs;
    logic        as;
    logic        rw;
    logic [1:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rdy;

    modport master (
        output cs,
        output as,
        output rw,
        output addr,
        output wr_data,
        input  rd_data,
        input  rdy
    );

    modport slave (
        input  cs,
        input  as,
        input  rw,
        input  addr,
        input  wr_data,
        output rd_data,
        output rdy
    );
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl
// Purpose: peripheral interrupt controller. It synchronizes the raw source
//          lines and latches edge or level events into a pending register.
//          Pending bits are gated with a per-source enable. The registered
//          request vector goes to the CPU, together with the index of the
//          lowest-numbered active request.
// Ports:
//   clk      - system clock
//   rst      - synchronous active-high reset
//   src_irq  - raw interrupt lines, asynchronous to clk
//   bus      - register-access slave port (see irq_ctrl_if)
//   irq      - registered request vector (pend & en)
//   irq_any  - registered OR of irq
//   irq_id   - registered index of the lowest set bit of irq, 0 when none
// Registers (addr):
//   0 PEND  read pend, write-1-to-clear on edge-mode bits
//   1 EN    per-source enable
//   2 TRIG  1 = rising-edge mode, 0 = level mode
//   3 ID    read-only {irq_any, zeros, irq_id}
module irq_ctrl #(
    parameter int IRQ_W = 8,
    parameter int ID_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IRQ_W-1:0] src_irq,
    irq_ctrl_if.slave        bus,
    output logic [IRQ_W-1:0] irq,
    output logic             irq_any,
    output logic [ID_W-1:0]  irq_id
);

    localparam logic [1:0] ADDR_PEND = 2'd0;
    localparam logic [1:0] ADDR_EN   = 2'd1;
    localparam logic [1:0] ADDR_TRIG = 2'd2;

    logic [IRQ_W-1:0] s1;
    logic [IRQ_W-1:0] s2;
    logic [IRQ_W-1:0] s3;
    logic [IRQ_W-1:0] pend;
    logic [IRQ_W-1:0] en;
    logic [IRQ_W-1:0] trig;

    logic [IRQ_W-1:0] pend_next;
    logic [IRQ_W-1:0] rise;
    logic [IRQ_W-1:0] clr;
    logic [IRQ_W-1:0] req;
    logic [ID_W-1:0]  req_id;
    logic [31:0]      rd_mux;
    logic             access;
    logic             wr_en;
    logic             unused_wr_bits;

    assign access = bus.cs & bus.as;
    assign wr_en  = access & ~bus.rw;

    // s2 is the synchronized source; s3 is one cycle older and is used only
    // to spot a 0->1 transition.
    assign rise = s2 & ~s3;
    assign req  = pend & en;

    // Write data above the source count has no register behind it.
    assign unused_wr_bits = ^bus.wr_data[31:IRQ_W];

    always_comb begin
        clr = '0;
        if (wr_en && bus.addr == ADDR_PEND) begin
            clr = bus.wr_data[IRQ_W-1:0];
        end
    end

    // Level-mode bits track the synchronized line directly, so software
    // cannot clear them. Edge-mode bits give a new rising edge priority over
    // a clear in the same cycle, so a simultaneous event is not lost.
    always_comb begin
        pend_next = pend;
        for (int i = 0; i < IRQ_W; i++) begin
            if (!trig[i]) begin
                pend_next[i] = s2[i];
            end else if (rise[i]) begin
                pend_next[i] = 1'b1;
            end else if (clr[i]) begin
                pend_next[i] = 1'b0;
            end
        end
    end

    // Lowest index wins. The scan goes downward so that the last match,
    // which is the smallest index, is the one that sticks.
    always_comb begin
        req_id = '0;
        for (int i = IRQ_W - 1; i >= 0; i--) begin
            if (req[i]) begin
                req_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            ADDR_PEND: rd_mux[IRQ_W-1:0] = pend;
            ADDR_EN:   rd_mux[IRQ_W-1:0] = en;
            ADDR_TRIG: rd_mux[IRQ_W-1:0] = trig;
            default: begin
                rd_mux[31]       = irq_any;
                rd_mux[ID_W-1:0] = irq_id;
            end
        endcase
    end

    // irq, irq_any and irq_id all come from the same req sample, so the CPU
    // never sees them disagree. Reset drops any access in flight, so no rdy
    // follows an access that coincides with reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1          <= '0;
            s2          <= '0;
            s3          <= '0;
            pend        <= '0;
            en          <= '0;
            trig        <= '0;
            irq         <= '0;
            irq_any     <= 1'b0;
            irq_id      <= '0;
            bus.rdy     <= 1'b0;
            bus.rd_data <= '0;
        end else begin
            s1   <= src_irq;
            s2   <= s1;
            s3   <= s2;
            pend <= pend_next;
            if (wr_en && bus.addr == ADDR_EN) begin
                en <= bus.wr_data[IRQ_W-1:0];
            end
            if (wr_en && bus.addr == ADDR_TRIG) begin
                trig <= bus.wr_data[IRQ_W-1:0];
            end
            irq         <= req;
            irq_any     <= |req;
            irq_id      <= req_id;
            bus.rdy     <= access;
            bus.rd_data <= (access && bus.rw) ? rd_mux : '0;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl
// Purpose: self-checking bench for irq_ctrl. Directed scenarios exercise
//          reset, edge and level modes, priority, the set/clear collision,
//          back-to-back accesses and mid-access reset. A randomized phase
//          compares every output each cycle against a reference model.
module tb_irq_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] src_irq;
    logic [W-1:0] irq;
    logic         irq_any;
    logic [2:0]   irq_id;

    int compared   = 0;
    int mismatched = 0;

    irq_ctrl_if bus ();

    irq_ctrl #(
        .IRQ_W(W),
        .ID_W (3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .src_irq(src_irq),
        .bus    (bus),
        .irq    (irq),
        .irq_any(irq_any),
        .irq_id (irq_id)
    );

    always #5 clk = ~clk;

    // Reference model state. m_sync[0] is the newest sample of the source
    // lines, and m_sync[1] is the sample the pending logic acts on.
    logic [W-1:0] m_sync [3];
    logic [W-1:0] m_pend;
    logic [W-1:0] m_en;
    logic [W-1:0] m_trig;
    logic [W-1:0] m_irq;
    logic         m_rdy;
    logic [31:0]  m_rd;

    function automatic logic [2:0] lowest_set(input logic [W-1:0] v);
        for (int i = 0; i < W; i++) begin
            if (v[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    // The reference model advances on every rising edge. It uses the inputs
    // the bench drove at the preceding falling edge.
    always @(posedge clk) begin : ref_model
        logic         acc;
        logic [W-1:0] rise;
        logic [W-1:0] clr;
        logic [W-1:0] np;
        logic [31:0]  rv;
        acc = bus.cs & bus.as;
        if (rst) begin
            for (int k = 0; k < 3; k++) m_sync[k] <= '0;
            m_pend <= '0;
            m_en   <= '0;
            m_trig <= '0;
            m_irq  <= '0;
            m_rdy  <= 1'b0;
            m_rd   <= '0;
        end else begin
            rise = m_sync[1] & ~m_sync[2];
            clr  = (acc && !bus.rw && bus.addr == 2'd0) ? bus.wr_data[W-1:0] : '0;
            for (int i = 0; i < W; i++) begin
                np[i] = m_trig[i] ? (rise[i] | (m_pend[i] & ~clr[i])) : m_sync[1][i];
            end
            case (bus.addr)
                2'd0:    rv = {24'h0, m_pend};
                2'd1:    rv = {24'h0, m_en};
                2'd2:    rv = {24'h0, m_trig};
                default: rv = {(m_irq != '0), 28'h0, lowest_set(m_irq)};
            endcase
            m_sync[0] <= src_irq;
            m_sync[1] <= m_sync[0];
            m_sync[2] <= m_sync[1];
            m_pend    <= np;
            if (acc && !bus.rw && bus.addr == 2'd1) m_en   <= bus.wr_data[W-1:0];
            if (acc && !bus.rw && bus.addr == 2'd2) m_trig <= bus.wr_data[W-1:0];
            m_irq <= m_pend & m_en;
            m_rdy <= acc;
            m_rd  <= (acc && bus.rw) ? rv : 32'h0;
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive_bus(input logic sel, input logic r, input logic [1:0] a,
                             input logic [31:0] d);
        bus.cs      = sel;
        bus.as      = sel;
        bus.rw      = r;
        bus.addr    = a;
        bus.wr_data = d;
    endtask

    // Issues one access and returns in the cycle that carries its response.
    task automatic do_access(input logic r, input logic [1:0] a, input logic [31:0] d);
        drive_bus(1'b1, r, a, d);
        step();
        drive_bus(1'b0, 1'b0, 2'd0, 32'h0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        compared++;
        if (bus.rdy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_rdy: got %b expected 0", bus.rdy);
        end
        compared++;
        if (bus.rd_data !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_rd_data: got %h expected 00000000", bus.rd_data);
        end
        compared++;
        if (irq !== 8'h00 || irq_any !== 1'b0 || irq_id !== 3'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_irq: got irq=%h any=%b id=%0d expected 00/0/0",
                     irq, irq_any, irq_id);
        end
        for (int a = 0; a < 4; a++) begin
            do_access(1'b1, 2'(a), 32'h0);
            compared++;
            if (bus.rdy !== 1'b1 || bus.rd_data !== 32'h0) begin
                mismatched++;
                $display("[TB] FAIL reset_read_reg%0d: got rdy=%b data=%h expected 1/00000000",
                         a, bus.rdy, bus.rd_data);
            end
        end
        step();
        compared++;
        if (bus.rdy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rdy_single_cycle: got %b expected 0", bus.rdy);
        end
    endtask

    task automatic test_edge_latch();
        do_access(1'b0, 2'd2, 32'h01);
        do_access(1'b0, 2'd1, 32'h01);
        src_irq[0] = 1'b1;
        step();
        src_irq[0] = 1'b0;
        step();
        step();
        compared++;
        if (irq !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL edge_latency_early: got %h expected 00", irq);
        end
        step();
        compared++;
        if (irq !== 8'h01 || irq_id !== 3'd0 || irq_any !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL edge_latch: got irq=%h id=%0d any=%b expected 01/0/1",
                     irq, irq_id, irq_any);
        end
        repeat (3) step();
        compared++;
        if (irq !== 8'h01) begin
            mismatched++;
            $display("[TB] FAIL edge_hold: got %h expected 01", irq);
        end
        do_access(1'b0, 2'd0, 32'h01);
        compared++;
        if (irq !== 8'h01) begin
            mismatched++;
            $display("[TB] FAIL edge_clear_early: got %h expected 01", irq);
        end
        step();
        compared++;
        if (irq !== 8'h00 || irq_any !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL edge_clear: got irq=%h any=%b expected 00/0", irq, irq_any);
        end
    endtask

    task automatic test_level();
        do_access(1'b0, 2'd2, 32'h00);
        do_access(1'b0, 2'd1, 32'h80);
        src_irq[7] = 1'b1;
        repeat (4) step();
        compared++;
        if (irq !== 8'h80 || irq_id !== 3'd7) begin
            mismatched++;
            $display("[TB] FAIL level_irq: got irq=%h id=%0d expected 80/7", irq, irq_id);
        end
        do_access(1'b1, 2'd3, 32'h0);
        compared++;
        if (bus.rd_data !== 32'h8000_0007) begin
            mismatched++;
            $display("[TB] FAIL level_id_read: got %h expected 80000007", bus.rd_data);
        end
        do_access(1'b0, 2'd0, 32'h80);
        step();
        compared++;
        if (irq !== 8'h80) begin
            mismatched++;
            $display("[TB] FAIL level_no_clear: got %h expected 80", irq);
        end
        src_irq[7] = 1'b0;
        repeat (3) step();
        compared++;
        if (irq !== 8'h80) begin
            mismatched++;
            $display("[TB] FAIL level_drop_early: got %h expected 80", irq);
        end
        step();
        compared++;
        if (irq !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL level_drop: got %h expected 00", irq);
        end
    endtask

    task automatic test_priority();
        do_access(1'b0, 2'd1, 32'hFF);
        src_irq = 8'h24;
        repeat (4) step();
        compared++;
        if (irq !== 8'h24 || irq_id !== 3'd2 || irq_any !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL prio_both: got irq=%h id=%0d any=%b expected 24/2/1",
                     irq, irq_id, irq_any);
        end
        src_irq[2] = 1'b0;
        repeat (4) step();
        compared++;
        if (irq !== 8'h20 || irq_id !== 3'd5) begin
            mismatched++;
            $display("[TB] FAIL prio_single: got irq=%h id=%0d expected 20/5", irq, irq_id);
        end
        src_irq = 8'h00;
        repeat (4) step();
    endtask

    task automatic test_collision();
        do_access(1'b0, 2'd2, 32'h08);
        do_access(1'b0, 2'd1, 32'h08);
        src_irq[3] = 1'b1;
        step();
        src_irq[3] = 1'b0;
        repeat (4) step();
        compared++;
        if (irq !== 8'h08) begin
            mismatched++;
            $display("[TB] FAIL collide_setup: got %h expected 08", irq);
        end
        // The new edge reaches the detector two edges after it is first
        // sampled, which is the edge that also performs the clear.
        src_irq[3] = 1'b1;
        step();
        step();
        drive_bus(1'b1, 1'b0, 2'd0, 32'h08);
        step();
        drive_bus(1'b0, 1'b0, 2'd0, 32'h0);
        step();
        do_access(1'b1, 2'd0, 32'h0);
        compared++;
        if (bus.rd_data !== 32'h08) begin
            mismatched++;
            $display("[TB] FAIL collide_set_wins: got %h expected 00000008", bus.rd_data);
        end
        compared++;
        if (irq !== 8'h08) begin
            mismatched++;
            $display("[TB] FAIL collide_irq: got %h expected 08", irq);
        end
        do_access(1'b0, 2'd0, 32'h08);
        step();
        compared++;
        if (irq !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL collide_later_clear: got %h expected 00", irq);
        end
        src_irq = 8'h00;
        repeat (3) step();
    endtask

    task automatic test_back_to_back();
        drive_bus(1'b1, 1'b0, 2'd1, 32'hFFFF_FF3C);
        step();
        compared++;
        if (bus.rdy !== 1'b1 || bus.rd_data !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL b2b_write_resp: got rdy=%b data=%h expected 1/00000000",
                     bus.rdy, bus.rd_data);
        end
        drive_bus(1'b1, 1'b1, 2'd1, 32'h0);
        step();
        drive_bus(1'b0, 1'b0, 2'd0, 32'h0);
        compared++;
        if (bus.rdy !== 1'b1 || bus.rd_data !== 32'h3C) begin
            mismatched++;
            $display("[TB] FAIL b2b_read_new: got rdy=%b data=%h expected 1/0000003c",
                     bus.rdy, bus.rd_data);
        end
        step();
        compared++;
        if (bus.rdy !== 1'b0 || bus.rd_data !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL b2b_idle: got rdy=%b data=%h expected 0/00000000",
                     bus.rdy, bus.rd_data);
        end
    endtask

    task automatic test_reset_mid_access();
        do_access(1'b1, 2'd1, 32'h0);
        compared++;
        if (bus.rd_data !== 32'h3C) begin
            mismatched++;
            $display("[TB] FAIL midrst_pre_read: got %h expected 0000003c", bus.rd_data);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        compared++;
        if (bus.rdy !== 1'b0 || bus.rd_data !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL midrst_after: got rdy=%b data=%h expected 0/00000000",
                     bus.rdy, bus.rd_data);
        end
        do_access(1'b0, 2'd1, 32'h11);
        drive_bus(1'b1, 1'b1, 2'd1, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive_bus(1'b0, 1'b0, 2'd0, 32'h0);
        compared++;
        if (bus.rdy !== 1'b0 || bus.rd_data !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL midrst_dropped: got rdy=%b data=%h expected 0/00000000",
                     bus.rdy, bus.rd_data);
        end
        do_access(1'b1, 2'd1, 32'h0);
        compared++;
        if (bus.rdy !== 1'b1 || bus.rd_data !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL midrst_en_cleared: got rdy=%b data=%h expected 1/00000000",
                     bus.rdy, bus.rd_data);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            compared++;
            if (bus.rdy !== m_rdy || bus.rd_data !== m_rd) begin
                mismatched++;
                $display("[TB] FAIL rand_bus cyc %0d: got rdy=%b data=%h expected %b/%h",
                         n, bus.rdy, bus.rd_data, m_rdy, m_rd);
            end
            compared++;
            if (irq !== m_irq || irq_any !== (m_irq != '0) || irq_id !== lowest_set(m_irq)) begin
                mismatched++;
                $display("[TB] FAIL rand_irq cyc %0d: got irq=%h any=%b id=%0d expected %h/%b/%0d",
                         n, irq, irq_any, irq_id, m_irq, (m_irq != '0), lowest_set(m_irq));
            end
            if ($urandom_range(3) == 0) src_irq = W'($urandom);
            bus.cs      = 1'($urandom_range(1));
            bus.as      = 1'($urandom_range(1));
            bus.rw      = 1'($urandom_range(1));
            bus.addr    = 2'($urandom_range(3));
            bus.wr_data = $urandom;
            rst         = ($urandom_range(149) == 0);
            step();
        end
        rst = 1'b0;
        drive_bus(1'b0, 1'b0, 2'd0, 32'h0);
    endtask

    initial begin
        rst     = 1'b1;
        src_irq = '0;
        drive_bus(1'b0, 1'b0, 2'd0, 32'h0);
        step();
        test_reset();
        test_edge_latch();
        test_level();
        test_priority();
        test_collision();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Peripheral interrupt controller between the SoC interrupt sources and the CPU `irq` input. It synchronizes raw source lines and latches edge-triggered events into a pending register. It gates pending bits with a per-source enable and drives the prioritized request vector to the CPU core. Software configures and services it through a single-cycle-response bus slave port.

## Interface
- `IRQ_W`, default 8: number of sources; equals the CPU `irq` width (must be ≤ 31).
- `ID_W`, default 3: width of `irq_id`; equals clog2(`IRQ_W`).
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `src_irq` in `IRQ_W`: raw interrupt lines, asynchronous to `clk`.
- `cs` in 1: slave select.
- `as` in 1: address strobe; an access occurs in every cycle with `cs & as`.
- `rw` in 1: 1 = read, 0 = write.
- `addr` in 2: word register index.
- `wr_data` in 32: write data.
- `rd_data` out 32: read data; valid only while `rdy`, 0 otherwise.
- `rdy` out 1: access-complete strobe.
- `irq` out `IRQ_W`: registered request vector to the CPU (`pend & en`).
- `irq_any` out 1: registered; equals `|irq`.
- `irq_id` out `ID_W`: registered index of the highest-priority bit set in `irq`; 0 when `irq_any` = 0.

## Operation
- **Synchronizer:** per source, flops `s1 <= src_irq` and `s2 <= s1`. A third flop `s3 <= s2` serves edge detection.
- **Registers** (by `addr`):
  - 0 PEND: read returns {0, pend}. Write is write-1-to-clear on edge-mode bits; level-mode bits ignore the write.
  - 1 EN: read/write, `en[IRQ_W-1:0]`.
  - 2 TRIG: read/write; bit = 1 selects rising-edge mode, 0 selects level mode.
  - 3 ID: read-only, returns {irq_any at bit 31, zeros, irq_id}. Writes are ignored.
- **Level-mode bit:** `pend[i] <= s2[i]` every cycle. It cannot be cleared by software; the source must deassert.
- **Edge-mode bit:** set when `s2[i] & ~s3[i]`; cleared by a PEND write with `wr_data[i]` = 1; otherwise holds.
  - Set and clear in the same cycle: set wins and the bit stays 1.
- **TRIG change:**
  - Level→edge: `pend` keeps its last value.
  - Edge→level: `pend` reloads from `s2` on the next edge.
- **Priority:** lowest index wins. `irq`, `irq_any` and `irq_id` are all registered from the same `pend & en` sample, so they are always mutually consistent.
- **Read data:** a PEND read returns the value before any clear issued in the same cycle (reads and writes are distinct cycles, so this applies only to back-to-back access).
- **Out-of-range bits:** bits of `wr_data` above `IRQ_W` are ignored. Read bits above `IRQ_W` return 0, except ID bit 31.

## Timing
- **Reset values:** `rdy` 0, `rd_data` 0, `irq` 0, `irq_any` 0, `irq_id` 0. Internal `pend`, `en`, `trig`, `s1`, `s2`, `s3` all 0 (all sources level-mode, disabled).
- **Bus:**
  - Access in cycle N → `rdy` = 1 for exactly cycle N+1, with `rd_data` valid in N+1 for reads.
  - A write takes effect at the edge ending cycle N.
  - Back-to-back accesses are allowed: each cycle with `cs & as` produces its own `rdy` one cycle later.
  - Write in N followed by a read of the same register in N+1 returns the new value in N+2.
- **Source latency:** `src_irq` first sampled high at edge E → `s1` at E, `s2` at E+1, `pend` at E+2, `irq` / `irq_id` / `irq_any` at E+3.
- **Enable latency:**
  - EN write in cycle N with `pend` already set → `irq` rises at the edge ending N+1.
  - PEND clear in cycle N → `irq` falls at the edge ending N+1.
- **Mid-operation reset:** `rst` in any cycle forces all reset values at that edge. An access in flight is dropped: no `rdy` the following cycle.
- **Edge mode:** a pulse ≥ 1 `clk` cycle wide is never lost. Pulses narrower than a cycle may be missed.

## Test plan
- **Reset defaults:** reset, then read regs 0-3 → all return 0 with `rdy` one cycle after each access; `irq` = 0.
- **Edge latch and clear:** TRIG = 0x01, EN = 0x01; pulse `src_irq[0]` for 1 cycle → `irq` = 0x01, `irq_id` = 0 at E+3 and held after the pulse ends. Write PEND 0x01 → `irq` = 0 two edges later.
- **Level mode:** TRIG = 0, EN = 0x80; hold `src_irq[7]` high → `irq` = 0x80, ID read = 0x80000007. PEND write 0x80 → no change. Drop the source → `irq` = 0 three edges later.
- **Priority:** EN = 0xFF, assert sources 5 and 2 together → `irq` = 0x24, `irq_id` = 2. Clear source 2 → `irq_id` = 5.
- **Set/clear collision:** edge source 3 pending; issue a PEND clear in the same cycle a new rising edge reaches `s2 & ~s3` → `pend[3]` stays 1.
- **Reset mid-access:** assert `rst` in the cycle after a read with `cs & as` → `rdy` = 0 and `rd_data` = 0 the following cycle; `en` back to 0.
